pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Instruction-fetch stage of the pipelined MIPS core. Holds the program counter, selects the next PC (sequential, branch, jump, register jump) and drives the IF/ID pipeline register. It supplies `pc_page` to the jump-address shifter and consumes the shifter's `shifted_address` as its jump target. Hazard and branch/jump decode logic in ID drive its stall and redirect controls.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  from the hazard unit; holds the PC and IF/ID.
- `pc_src`  in  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jr.
- `branch_addr`  in  32  branch target from ID.
- `jump_addr`  in  32  jump target (`shifted_address` from the jump shifter).
- `jr_addr`  in  32  register-jump target from ID.
- `imem_inst`  in  32  instruction-memory read data for the current `pc` (combinational memory).
- `pc`  out  32  current PC; instruction-memory address.
- `if_id_inst`  out  32  latched instruction.
- `if_id_pc4`  out  32  latched PC+4 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `pc_page`  out  4  `if_id_pc4[31:28]`, combinational from the register, fed to the jump shifter.
- `addr_err`  out  1  sticky misaligned-target flag.

## Operation
- Redirect: `pc_src != 00`. Target: 01 `branch_addr`, 10 `jump_addr`, 11 `jr_addr`.
- Priority when not in reset: redirect > stall > sequential.
  - Redirect: `pc` <= target with bits [1:0] forced to 00. IF/ID is flushed: `if_id_inst` <= 0 (nop), `if_id_pc4` <= 0, `if_id_valid` <= 0.
  - Redirect ignores `stall`. ID must not assert a redirect based on operands that are still stalled.
  - Stall, no redirect: `pc` and all IF/ID outputs hold.
  - Sequential: `pc` <= `pc + 4`, with modulo 2^32 wrap (32'hFFFF_FFFC -> 32'h0000_0000). `if_id_inst` <= `imem_inst`, `if_id_pc4` <= `pc + 4`, `if_id_valid` <= 1.
- `addr_err`:
  - Set on any redirect edge where the selected target has bits [1:0] != 00.
  - Stays set until `rst`.
  - Does not block the redirect.
- `pc` bits [1:0] are always 00.

## Timing
- Reset values, with `rst` high at an edge:
  - `pc` = `RESET_PC`
  - `if_id_inst` = 0, `if_id_pc4` = 0, `if_id_valid` = 0
  - `addr_err` = 0
  - `pc_page` = 0
  - all counters = 0
- Reset overrides stall and redirect and may arrive mid-operation; any in-flight redirect is discarded.
- First edge after `rst` falls: IF/ID captures the instruction at `RESET_PC`, and `pc` = `RESET_PC + 4`.
- Redirect sampled at edge n:
  - `pc` = target after edge n.
  - Bubble in IF/ID after edge n.
  - Target instruction in IF/ID after edge n+1.
  - Redirect penalty: 1 cycle.
- Sequential fetch: 1 instruction per cycle. Latency from `pc` to IF/ID is 1 edge.
- Stall held for k cycles: outputs are frozen for exactly k edges.
- Back-to-back redirects: each one takes effect. IF/ID stays a bubble while redirects continue.

## Configuration
- `FETCH_PERF_CNT_EN`
  - Defined: adds outputs `fetch_cnt` (32) and `flush_cnt` (32).
    - `fetch_cnt` increments on each edge that loads `if_id_valid` = 1.
    - `flush_cnt` increments on each redirect edge.
    - Both wrap modulo 2^32, reset to 0, and do not change on stall edges.
  - Undefined: neither port nor its logic exists. All other behaviour is identical.

## Test plan
- Reset:
  - Stimulus: `RESET_PC` = 32'h0040_0000, `rst` high for 2 cycles, then release, with `imem_inst` = 32'h2008_0005.
  - Response: during reset `pc` = 32'h0040_0000 and `if_id_valid` = 0. After the first edge, `if_id_inst` = 32'h2008_0005, `if_id_pc4` = 32'h0040_0004, `pc` = 32'h0040_0004.
- Jump:
  - Stimulus: `pc_src` = 10, `jump_addr` = 32'h800E_38EC for 1 edge.
  - Response: `pc` = 32'h800E_38EC and bubble in IF/ID. Next edge: `if_id_pc4` = 32'h800E_38F0 and `pc_page` = 4'h8.
- Stall:
  - Stimulus: `stall` = 1 for 3 cycles at `pc` = 32'h0000_0010.
  - Response: `pc` and IF/ID are unchanged for 3 edges; fetch of 32'h0000_0010 resumes on the 4th edge.
- Stall plus redirect:
  - Stimulus: `stall` = 1 together with `pc_src` = 01, `branch_addr` = 32'h0000_0100.
  - Response: `pc` = 32'h0000_0100 and `if_id_valid` = 0.
- Wrap and misalignment:
  - Stimulus: `pc` = 32'hFFFF_FFFC sequential, then `pc_src` = 11 with `jr_addr` = 32'h0000_0203.
  - Response: `pc` goes to 32'h0000_0000, then to 32'h0000_0200 with `addr_err` = 1. `addr_err` stays 1 until `rst`.
- Performance counters, with `FETCH_PERF_CNT_EN` defined:
  - Stimulus: 5 sequential fetches, 2 redirects, 1 stall.
  - Response: `fetch_cnt` = 5 and `flush_cnt` = 2.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch stage; holds the PC, selects next PC, drives IF/ID.
// Latency: PC -> IF/ID in 1 edge; redirect penalty 1 cycle (bubble after redirect edge).
// Backpressure: stall freezes PC and IF/ID; a redirect overrides stall; reset overrides all.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             hold PC and IF/ID
//   pc_src            00 PC+4, 01 branch_addr, 10 jump_addr, 11 jr_addr
//   imem_inst         combinational instruction-memory data for pc
//   pc                current PC (instruction-memory address), bits [1:0] always 00
//   if_id_inst/pc4/valid  IF/ID pipeline register
//   pc_page           if_id_pc4[31:28], to the jump-address shifter
//   addr_err          sticky flag: a redirect target was not word aligned
//   fetch_cnt, flush_cnt  present only when FETCH_PERF_CNT_EN is defined
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_addr,
  input  logic [31:0] jump_addr,
  input  logic [31:0] jr_addr,
  input  logic [31:0] imem_inst,
  output logic [31:0] pc,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [3:0]  pc_page,
  output logic        addr_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign redirect = (pc_src != 2'b00);
  assign pc_plus4 = pc + 32'd4;
  assign pc_page  = if_id_pc4[31:28];

  always_comb begin
    target = branch_addr;
    case (pc_src)
      2'b01:   target = branch_addr;
      2'b10:   target = jump_addr;
      2'b11:   target = jr_addr;
      default: target = branch_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_id_inst  <= 32'd0;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else if (redirect) begin
      // Low bits are forced clear so pc stays word aligned even on a bad target;
      // the misalignment is only reported, never allowed to block the redirect.
      pc          <= {target[31:2], 2'b00};
      if_id_inst  <= 32'd0;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
      if (target[1:0] != 2'b00) begin
        addr_err <= 1'b1;
      end
    end else if (!stall) begin
      pc          <= pc_plus4;
      if_id_inst  <= imem_inst;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else if (redirect) begin
      flush_cnt <= flush_cnt + 32'd1;
    end else if (!stall) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [1:0]  pc_src;
  logic [31:0] branch_addr, jump_addr, jr_addr, imem_inst;
  logic [31:0] pc, if_id_inst, if_id_pc4;
  logic        if_id_valid, addr_err;
  logic [3:0]  pc_page;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .pc_src      (pc_src),
    .branch_addr (branch_addr),
    .jump_addr   (jump_addr),
    .jr_addr     (jr_addr),
    .imem_inst   (imem_inst),
    .pc          (pc),
    .if_id_inst  (if_id_inst),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .pc_page     (pc_page),
    .addr_err    (addr_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  // Combinational instruction memory: a fixed word at RESET_PC, a hash elsewhere.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == RPC) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  assign imem_inst = mem_fn(pc);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Reference model of the architectural state.
  logic [31:0] m_pc, m_inst, m_pc4, m_fetch, m_flush;
  logic        m_valid, m_err;

  task automatic model_step(input logic r, input logic s, input logic [1:0] src,
                            input logic [31:0] b, input logic [31:0] j, input logic [31:0] jr);
    logic [31:0] tg [4];
    tg = '{32'd0, b, j, jr};
    if (r) begin
      m_pc = RPC; m_inst = 0; m_pc4 = 0; m_valid = 0; m_err = 0; m_fetch = 0; m_flush = 0;
    end else if (src != 0) begin
      if (tg[src] % 4 != 0) m_err = 1;
      m_pc = tg[src] - (tg[src] % 4);
      m_inst = 0; m_pc4 = 0; m_valid = 0;
      m_flush = m_flush + 1;
    end else if (!s) begin
      m_inst = mem_fn(m_pc);
      m_pc = m_pc + 4;
      m_pc4 = m_pc;
      m_valid = 1;
      m_fetch = m_fetch + 1;
    end
  endtask

  // Drive inputs for one cycle (called at negedge), advance the model, return at next negedge.
  task automatic apply(input logic r, input logic s, input logic [1:0] src,
                       input logic [31:0] b, input logic [31:0] j, input logic [31:0] jr);
    rst = r; stall = s; pc_src = src; branch_addr = b; jump_addr = j; jr_addr = jr;
    @(posedge clk);
    model_step(r, s, src, b, j, jr);
    @(negedge clk);
  endtask

  typedef struct {
    logic        rst, stall;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic [31:0] e_pc, e_inst, e_pc4;
    logic        e_valid, e_err;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic [1:0] src,
                              input logic [31:0] tgt, input logic [31:0] e_pc,
                              input logic [31:0] e_inst, input logic [31:0] e_pc4,
                              input logic e_valid, input logic e_err);
    vec_t v;
    v.rst = r; v.stall = s; v.src = src; v.tgt = tgt;
    v.e_pc = e_pc; v.e_inst = e_inst; v.e_pc4 = e_pc4; v.e_valid = e_valid; v.e_err = e_err;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    // Same target on all three buses; pc_src picks which one is meant.
    vecs.push_back(mk(1, 0, 2'b00, 0,            RPC,          0,                  0,            0, 0));
    vecs.push_back(mk(1, 0, 2'b00, 0,            RPC,          0,                  0,            0, 0));
    vecs.push_back(mk(0, 0, 2'b00, 0,            RPC + 4,      32'h2008_0005,      RPC + 4,      1, 0));
    vecs.push_back(mk(0, 0, 2'b10, 32'h800E_38EC, 32'h800E_38EC, 0,                0,            0, 0));
    vecs.push_back(mk(0, 0, 2'b00, 0,            32'h800E_38F0, mem_fn(32'h800E_38EC), 32'h800E_38F0, 1, 0));
    vecs.push_back(mk(0, 0, 2'b01, 32'h0000_000C, 32'h0000_000C, 0,                0,            0, 0));
    vecs.push_back(mk(0, 0, 2'b00, 0,            32'h10,       mem_fn(32'hC),      32'h10,       1, 0));
    vecs.push_back(mk(0, 1, 2'b00, 0,            32'h10,       mem_fn(32'hC),      32'h10,       1, 0));
    vecs.push_back(mk(0, 1, 2'b00, 0,            32'h10,       mem_fn(32'hC),      32'h10,       1, 0));
    vecs.push_back(mk(0, 1, 2'b00, 0,            32'h10,       mem_fn(32'hC),      32'h10,       1, 0));
    vecs.push_back(mk(0, 0, 2'b00, 0,            32'h14,       mem_fn(32'h10),     32'h14,       1, 0));
    vecs.push_back(mk(0, 1, 2'b01, 32'h0000_0100, 32'h100,     0,                  0,            0, 0));
    vecs.push_back(mk(0, 0, 2'b11, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0,                0,            0, 0));
    vecs.push_back(mk(0, 0, 2'b00, 0,            32'h0,        mem_fn(32'hFFFF_FFFC), 32'h0,     1, 0));
    vecs.push_back(mk(0, 0, 2'b11, 32'h0000_0203, 32'h200,     0,                  0,            0, 1));
    vecs.push_back(mk(0, 0, 2'b00, 0,            32'h204,      mem_fn(32'h200),    32'h204,      1, 1));
    vecs.push_back(mk(0, 0, 2'b10, 32'h0000_3000, 32'h3000,    0,                  0,            0, 1));
    vecs.push_back(mk(0, 0, 2'b01, 32'h0000_0501, 32'h500,     0,                  0,            0, 1));
    vecs.push_back(mk(0, 1, 2'b00, 0,            32'h500,      0,                  0,            0, 1));
    vecs.push_back(mk(1, 0, 2'b01, 32'h0000_0800, RPC,         0,                  0,            0, 0));
    vecs.push_back(mk(0, 0, 2'b00, 0,            RPC + 4,      32'h2008_0005,      RPC + 4,      1, 0));

    rst = 1; stall = 0; pc_src = 0; branch_addr = 0; jump_addr = 0; jr_addr = 0;
    @(negedge clk);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].stall, vecs[i].src, vecs[i].tgt, vecs[i].tgt, vecs[i].tgt);
      chk($sformatf("vec%0d pc", i),    pc,          vecs[i].e_pc);
      chk($sformatf("vec%0d inst", i),  if_id_inst,  vecs[i].e_inst);
      chk($sformatf("vec%0d pc4", i),   if_id_pc4,   vecs[i].e_pc4);
      chk($sformatf("vec%0d valid", i), 32'(if_id_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d err", i),   32'(addr_err),    32'(vecs[i].e_err));
      chk($sformatf("vec%0d page", i),  32'(pc_page),     32'(vecs[i].e_pc4[31:28]));
    end

    // Counter sequence: reset, 5 fetches, 2 redirects, 1 stall.
    apply(1, 0, 2'b00, 0, 0, 0);
    for (int k = 0; k < 5; k++) apply(0, 0, 2'b00, 0, 0, 0);
    apply(0, 0, 2'b01, 32'h40, 0, 0);
    apply(0, 1, 2'b00, 0, 0, 0);
    apply(0, 0, 2'b10, 0, 32'h80, 0);
    chk("seq pc", pc, 32'h80);
    chk("seq valid", 32'(if_id_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, 32'd5);
    chk("flush_cnt", flush_cnt, 32'd2);
`endif

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      logic        r, s;
      logic [1:0]  src;
      logic [31:0] b, j, jr;
      r   = ($urandom_range(0, 63) == 0);
      s   = ($urandom_range(0, 3) == 0);
      src = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      b   = $urandom; j = $urandom; jr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        b[1:0] = 0; j[1:0] = 0; jr[1:0] = 0;
      end
      apply(r, s, src, b, j, jr);
      chk("rnd pc",    pc,               m_pc);
      chk("rnd inst",  if_id_inst,       m_inst);
      chk("rnd pc4",   if_id_pc4,        m_pc4);
      chk("rnd valid", 32'(if_id_valid), 32'(m_valid));
      chk("rnd err",   32'(addr_err),    32'(m_err));
      chk("rnd page",  32'(pc_page),     32'(m_pc4 >> 28));
`ifdef FETCH_PERF_CNT_EN
      chk("rnd fetch_cnt", fetch_cnt, m_fetch);
      chk("rnd flush_cnt", flush_cnt, m_flush);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
